// File: rtl/risc_cunit.sv
// Control unit for the small RISC core: sequences fetch/decode/execute/writeback and
// drives the ALU and register file. Define RISC_CUNIT_ILLEGAL_TRAP_EN to trap opcode 14.
module risc_cunit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [12:0] ir,
   output logic        ir_ld,
   output logic        pc_inc,
   output logic [3:0]  alu_op,
   output logic [2:0]  rd_addr,
   output logic [2:0]  rs1_addr,
   output logic [2:0]  rs2_addr,
   output logic        alu_en,
   output logic        rf_we,
   output logic [2:0]  state,
   output logic        halted,
   output logic        illegal,
   output logic [7:0]  retired
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   localparam logic [3:0] OP_NOP     = 4'd0;
   localparam logic [3:0] OP_ILLEGAL = 4'd14;
   localparam logic [3:0] OP_HALT    = 4'd15;

   // Opcodes 6..13 take a single source operand, so rs2 is forced to 0.
   function automatic logic is_unary(input logic [3:0] op);
      is_unary = (op >= 4'd6) && (op <= 4'd13);
   endfunction

   state_t      state_r;
   state_t      state_next_s;
   logic [3:0]  opcode_s;
   logic        leave_decode_s;
   logic        retire_s;
   logic        ir_ld_r;
   logic        pc_inc_r;
   logic        alu_en_r;
   logic        rf_we_r;
   logic        halted_r;
   logic [3:0]  alu_op_r;
   logic [2:0]  rd_addr_r;
   logic [2:0]  rs1_addr_r;
   logic [2:0]  rs2_addr_r;
   logic [7:0]  retired_r;
`ifdef RISC_CUNIT_ILLEGAL_TRAP_EN
   logic        trap_s;
   logic        illegal_r;
`endif

   assign opcode_s = ir[12:9];

   // Next-state decode and per-edge retire/trap qualifiers.
   always_comb begin
      state_next_s   = S_IDLE;
      leave_decode_s = 1'b0;
      retire_s       = 1'b0;
`ifdef RISC_CUNIT_ILLEGAL_TRAP_EN
      trap_s         = 1'b0;
`endif
      case (state_r)
         S_IDLE:      state_next_s = S_FETCH;
         S_FETCH:     state_next_s = S_DECODE;
         S_DECODE: begin
            leave_decode_s = 1'b1;
            if (opcode_s == OP_NOP) begin
               state_next_s = S_FETCH;
               retire_s     = 1'b1;
            end else if (opcode_s == OP_HALT) begin
               state_next_s = S_HALT;
            end else if (opcode_s == OP_ILLEGAL) begin
`ifdef RISC_CUNIT_ILLEGAL_TRAP_EN
               state_next_s = S_HALT;
               trap_s       = 1'b1;
`else
               state_next_s = S_FETCH;
               retire_s     = 1'b1;
`endif
            end else begin
               state_next_s = S_EXECUTE;
            end
         end
         S_EXECUTE:   state_next_s = S_WRITEBACK;
         S_WRITEBACK: begin
            state_next_s = S_FETCH;
            retire_s     = 1'b1;
         end
         S_HALT:      state_next_s = S_HALT;
         default:     state_next_s = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Strobes are registered from the next state so each is high exactly while in its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_ld_r  <= 1'b0;
         pc_inc_r <= 1'b0;
         alu_en_r <= 1'b0;
         rf_we_r  <= 1'b0;
         halted_r <= 1'b0;
      end else begin
         ir_ld_r  <= (state_next_s == S_FETCH);
         pc_inc_r <= (state_next_s == S_FETCH);
         alu_en_r <= (state_next_s == S_EXECUTE);
         rf_we_r  <= (state_next_s == S_WRITEBACK);
         halted_r <= (state_next_s == S_HALT);
      end
   end

   // Instruction fields are captured only on the DECODE exit edge and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op_r   <= 4'd0;
         rd_addr_r  <= 3'd0;
         rs1_addr_r <= 3'd0;
         rs2_addr_r <= 3'd0;
      end else if (leave_decode_s) begin
         alu_op_r   <= opcode_s;
         rd_addr_r  <= ir[8:6];
         rs1_addr_r <= ir[5:3];
         rs2_addr_r <= is_unary(opcode_s) ? 3'd0 : ir[2:0];
      end else begin
         alu_op_r   <= alu_op_r;
         rd_addr_r  <= rd_addr_r;
         rs1_addr_r <= rs1_addr_r;
         rs2_addr_r <= rs2_addr_r;
      end
   end

   // Retired-instruction counter; wraps naturally at 8 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_r <= 8'd0;
      end else if (retire_s) begin
         retired_r <= retired_r + 8'd1;
      end else begin
         retired_r <= retired_r;
      end
   end

`ifdef RISC_CUNIT_ILLEGAL_TRAP_EN
   // Sticky illegal-opcode flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_r <= 1'b0;
      end else begin
         illegal_r <= illegal_r | trap_s;
      end
   end
   assign illegal = illegal_r;
`else
   assign illegal = 1'b0;
`endif

   assign state    = state_r;
   assign ir_ld    = ir_ld_r;
   assign pc_inc   = pc_inc_r;
   assign alu_en   = alu_en_r;
   assign rf_we    = rf_we_r;
   assign halted   = halted_r;
   assign alu_op   = alu_op_r;
   assign rd_addr  = rd_addr_r;
   assign rs1_addr = rs1_addr_r;
   assign rs2_addr = rs2_addr_r;
   assign retired  = retired_r;

endmodule

// File: tb/tb_risc_cunit.sv
// Scoreboard bench for risc_cunit: stimulus pushes the expected per-cycle output vector,
// a monitor pops and compares it on the falling edge (or immediately after reset assertion).
`timescale 1ns/1ps
module tb_risc_cunit;

   typedef struct packed {
      logic [2:0] st;
      logic       ld;
      logic       inc;
      logic       aen;
      logic       we;
      logic       hlt;
      logic       ill;
      logic [7:0] ret;
      logic [3:0] op;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
   } rec_t;

   logic        clk;
   logic        rst_n;
   logic [12:0] ir;
   logic        ir_ld, pc_inc, alu_en, rf_we, halted, illegal;
   logic [3:0]  alu_op;
   logic [2:0]  rd_addr, rs1_addr, rs2_addr, state;
   logic [7:0]  retired;

   rec_t        exp_q[$];
   string       name_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   event        chk_ev;

   logic [3:0]  cur_op;
   logic [2:0]  cur_rd, cur_rs1, cur_rs2;
   logic [7:0]  cur_ret;
   logic        cur_ill;

   risc_cunit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ir       (ir),
      .ir_ld    (ir_ld),
      .pc_inc   (pc_inc),
      .alu_op   (alu_op),
      .rd_addr  (rd_addr),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .alu_en   (alu_en),
      .rf_we    (rf_we),
      .state    (state),
      .halted   (halted),
      .illegal  (illegal),
      .retired  (retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: pops one expected vector per falling edge or explicit check event.
   initial begin
      rec_t  e;
      rec_t  got;
      string nm;
      forever begin
         @(negedge clk or chk_ev);
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = '{state, ir_ld, pc_inc, alu_en, rf_we, halted, illegal,
                    retired, alu_op, rd_addr, rs1_addr, rs2_addr};
            n_checks++;
            if (got !== e)
               $display("FAIL %s: got st=%0d ld=%b inc=%b aen=%b we=%b hlt=%b ill=%b ret=%0d op=%0d rd=%0d rs1=%0d rs2=%0d, expected st=%0d ld=%b inc=%b aen=%b we=%b hlt=%b ill=%b ret=%0d op=%0d rd=%0d rs1=%0d rs2=%0d",
                        nm, got.st, got.ld, got.inc, got.aen, got.we, got.hlt, got.ill,
                        got.ret, got.op, got.rd, got.rs1, got.rs2,
                        e.st, e.ld, e.inc, e.aen, e.we, e.hlt, e.ill,
                        e.ret, e.op, e.rd, e.rs1, e.rs2);
            else
               n_pass++;
         end
      end
   end

   function automatic rec_t mk(input logic [2:0] st, input logic ld, input logic aen,
                               input logic we, input logic hlt);
      mk = '{st, ld, ld, aen, we, hlt, cur_ill, cur_ret, cur_op, cur_rd, cur_rs1, cur_rs2};
   endfunction

   task automatic push(input string nm, input rec_t r);
      exp_q.push_back(r);
      name_q.push_back(nm);
   endtask

   task automatic step(input string nm, input logic [2:0] st, input logic ld,
                       input logic aen, input logic we, input logic hlt);
      @(posedge clk);
      #1;
      push(nm, mk(st, ld, aen, we, hlt));
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      #1 rst_n = 1'b0;
      cur_op = 4'd0; cur_rd = 3'd0; cur_rs1 = 3'd0; cur_rs2 = 3'd0;
      cur_ret = 8'd0; cur_ill = 1'b0;
      #1;
      n_checks++;
      if (state !== 3'd0 || ir_ld !== 1'b0 || pc_inc !== 1'b0 || alu_en !== 1'b0 ||
          rf_we !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0 || retired !== 8'd0 ||
          alu_op !== 4'd0 || rd_addr !== 3'd0 || rs1_addr !== 3'd0 || rs2_addr !== 3'd0)
         $display("FAIL %s_direct: outputs not cleared by reset (st=%0d we=%b ret=%0d ill=%b)",
                  nm, state, rf_we, retired, illegal);
      else
         n_pass++;
      push({nm, "_immediate"}, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      ->chk_ev;
      push({nm, "_held"}, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_alu(input string nm, input logic [12:0] iv, input logic [3:0] op,
                          input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
      step({nm, "_fetch"}, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      ir = iv;
      step({nm, "_decode"}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      cur_op = op; cur_rd = rd; cur_rs1 = rs1; cur_rs2 = rs2;
      step({nm, "_execute"}, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      step({nm, "_writeback"}, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      cur_ret = cur_ret + 8'd1;
   endtask

   task automatic run_nop(input string nm, input logic [12:0] iv, input logic [3:0] op);
      step({nm, "_fetch"}, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      ir = iv;
      step({nm, "_decode"}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      cur_op = op; cur_rd = 3'd0; cur_rs1 = 3'd0; cur_rs2 = 3'd0;
      cur_ret = cur_ret + 8'd1;
   endtask

   task automatic run_halt(input string nm, input logic [12:0] iv, input logic [3:0] op,
                           input logic ill);
      step({nm, "_fetch"}, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      ir = iv;
      step({nm, "_decode"}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      cur_op = op; cur_rd = 3'd0; cur_rs1 = 3'd0; cur_rs2 = 3'd0;
      cur_ill = ill;
      for (int i = 0; i < 20; i++)
         step({nm, "_hold"}, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (state !== 3'd5 || halted !== 1'b1 || ir_ld !== 1'b0 || pc_inc !== 1'b0 ||
          alu_en !== 1'b0 || rf_we !== 1'b0 || illegal !== ill || retired !== cur_ret)
         $display("FAIL %s_expired: after wait st=%0d hlt=%b ld=%b aen=%b we=%b ill=%b ret=%0d",
                  nm, state, halted, ir_ld, alu_en, rf_we, illegal, retired);
      else
         n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      ir    = 13'h0000;

      // Basic ALU sequencing, field capture and unary rs2 zeroing.
      do_reset("rst0");
      run_alu("add", 13'h0208, 4'd1, 3'd0, 3'd1, 3'd0);
      run_alu("sub", 13'h05f1, 4'd2, 3'd7, 3'd6, 3'd1);
      run_alu("rol", 13'h1b04, 4'd13, 3'd4, 3'd0, 3'd0);

      // NOP timing, then opcode 14 in whichever build is compiled.
      do_reset("rst1");
      run_nop("nop1", 13'h0000, 4'd0);
      run_nop("nop2", 13'h0000, 4'd0);
      run_nop("nop3", 13'h0000, 4'd0);
`ifdef RISC_CUNIT_ILLEGAL_TRAP_EN
      run_halt("trap14", 13'h1c00, 4'd14, 1'b1);
      do_reset("rst2");
      run_alu("add2", 13'h0208, 4'd1, 3'd0, 3'd1, 3'd0);
`else
      run_nop("nop14", 13'h1c00, 4'd14);
`endif
      run_halt("halt", 13'h1e00, 4'd15, 1'b0);

      // Retired wrap at 255 and reset during WRITEBACK.
      do_reset("rst3");
      for (int i = 0; i < 255; i++)
         run_nop("pre", 13'h0000, 4'd0);
      run_alu("wrap", 13'h0208, 4'd1, 3'd0, 3'd1, 3'd0);
      step("wbrst_fetch", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      ir = 13'h05f1;
      step("wbrst_decode", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      cur_op = 4'd2; cur_rd = 3'd7; cur_rs1 = 3'd6; cur_rs2 = 3'd1;
      step("wbrst_execute", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      step("wbrst_writeback", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      do_reset("rst_wb");
      run_alu("post", 13'h0208, 4'd1, 3'd0, 3'd1, 3'd0);
      run_halt("halt2", 13'h1e00, 4'd15, 1'b0);

      @(negedge clk);
      @(negedge clk);
      if (n_pass != n_checks)
         $display("FAIL summary: %0d of %0d checks failed", n_checks - n_pass, n_checks);
      else
         $display("PASS summary");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
